fir_mac_scheduler: RTL and testbench
====================================

# fir_mac_scheduler

Time-multiplexed FIR engine for the two-channel (I/Q) post-CIC path. It arbitrates between two decimated sample streams and sequences one shared signed multiplier and accumulator through TAPS multiply-accumulate cycles per accepted sample. It also owns a host-writable coefficient RAM with safe, deferred update. It sits between the CIC decimators and the downstream spectrum/packetizer stage and replaces per-channel parallel FIR instances.

## Interface
- WIDTH, 32: signed sample width (input and output).
- COEFF_WIDTH, 16: signed Q1.(COEFF_WIDTH-1) coefficient width.
- TAPS, 8: taps per channel; power of two, 2..64.
- ACC_WIDTH, WIDTH+COEFF_WIDTH+clog2(TAPS): accumulator width.
- clk  in  1  processing clock.
- rst_n  in  1  asynchronous, active-low reset.
- ch0_data / ch1_data  in  WIDTH  signed samples, channel 0 / 1.
- ch0_valid / ch1_valid  in  1  sample offered.
- ch0_ready / ch1_ready  out  1  sample accepted when valid && ready.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  clog2(TAPS)  tap index.
- coef_wr_data  in  COEFF_WIDTH  signed coefficient.
- out_data  out  WIDTH  filtered, scaled, saturated result.
- out_ch  out  1  channel of out_data.
- out_valid  out  1  one-cycle result strobe.
- busy  out  1  high in MAC state.
- coef_drop  out  1  sticky: a pending coefficient write was overwritten.

## Operation
- Storage: one TAPS-deep circular sample buffer per channel, with write pointer wp[ch]; one shared coefficient RAM coeff[0..TAPS-1].
- FSM states: IDLE, MAC.
- IDLE:
  - grant = the only valid channel; if both are valid, the channel other than last_grant (round-robin).
  - chN_ready = (state==IDLE) && grant==N; ready is 0 in MAC.
  - On handshake: buf[ch][wp[ch]] <= data; base <= wp[ch]; wp[ch] <= wp[ch]+1 mod TAPS; k <= 0; acc <= 0; cur_ch <= ch; last_grant <= ch; state <= MAC.
- MAC, one tap per cycle for k = 0..TAPS-1:
  - acc += signed(buf[cur_ch][(base-k) mod TAPS]) * signed(coeff[k]), with full-precision signed product and ACC_WIDTH accumulation (no internal overflow).
  - After k = TAPS-1: state <= IDLE and the output is registered.
- Output:
  - s = acc >>> (COEFF_WIDTH-1), arithmetic shift.
  - If s > 2^(WIDTH-1)-1, out_data = 0x7FF..F; if s < -2^(WIDTH-1), out_data = 0x800..0; otherwise out_data = s[WIDTH-1:0].
  - out_ch = cur_ch; out_valid pulses for 1 cycle.
- Coefficient writes:
  - In IDLE: applied on the next clock edge.
  - In MAC: captured in a one-entry pending register and applied on the edge that leaves MAC. The result in progress always uses the coefficients as they were at acceptance.
  - A second write during the same MAC overwrites the pending entry (last wins) and sets coef_drop.
  - A write arriving on the cycle the pending entry is applied wins over the pending entry for the same address.
- Channels are fully independent: a sample never enters the other channel's buffer.

## Timing
- Reset values:
  - ch0_ready = ch1_ready = 0 while rst_n is low; after reset they follow the IDLE rule.
  - out_data = 0, out_ch = 0, out_valid = 0, busy = 0, coef_drop = 0.
  - Sample buffers = 0, wp = 0, last_grant = 1 (channel 0 wins the first tie).
  - coeff[0] = 0x4000 (gain 0.5), all other coeff = 0.
- Handshake at edge T: MAC occupies T+1..T+TAPS, and out_valid is high in cycle T+TAPS+1.
- Throughput: ready is high again in cycle T+TAPS+1, so the next handshake can occur at edge T+TAPS+1. One sample every TAPS+1 cycles, shared by both channels.
- busy is high exactly in cycles T+1..T+TAPS.
- valid may be held while not ready, and data must stay stable. A channel that drops valid before being granted loses nothing.
- Reset asserted mid-MAC: the operation aborts immediately, no out_valid is produced, the pending write is lost, and all state returns to reset values.

## Test plan
- Post-reset gain: ch0 sample 1000 handshake at edge T → out_data = 500, out_ch = 0, out_valid only in cycle T+9 (TAPS = 8); busy high for 8 cycles.
- Impulse response: write all coeff = 0x1000, then ch0 sample 8000 followed by seven 0s → outputs 1000 ×8; the ninth output = 0.
- Arbitration and isolation: both valid continuously, ch1 carries impulse 8000 and ch0 carries 0s, coeff all 0x1000 → grants alternate 0,1,0,1…; ch0 outputs remain 0; ch1 outputs 1000 ×8.
- Saturation: coeff all 0x7FFF, 8 samples of 0x7FFFFFFF on ch0 → out_data = 0x7FFFFFFF; repeat with 0x80000000 → out_data = 0x80000000.
- Deferred coefficient update:
  - Write coeff[0] = 0x2000 during MAC of sample 1000 → that result = 500; the next sample 1000 → 250; coef_drop = 0.
  - Two writes in one MAC → coef_drop = 1, the last write takes effect.
- Reset mid-MAC: assert rst_n low at T+3 → no out_valid; after release, ch0 sample 1000 → 500 and wp starts at 0.

Source files
------------

// File: rtl/fir_mac_scheduler.sv
// rtl/fir_mac_scheduler.sv - two-channel time-multiplexed FIR with one shared MAC and deferred coefficient RAM
module fir_mac_scheduler #(
    parameter int WIDTH       = 32,
    parameter int COEFF_WIDTH = 16,
    parameter int TAPS        = 8,
    parameter int ACC_WIDTH   = WIDTH + COEFF_WIDTH + $clog2(TAPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        ch0_data,
    input  logic                    ch0_valid,
    output logic                    ch0_ready,
    input  logic [WIDTH-1:0]        ch1_data,
    input  logic                    ch1_valid,
    output logic                    ch1_ready,
    input  logic                    coef_wr_en,
    input  logic [$clog2(TAPS)-1:0] coef_wr_addr,
    input  logic [COEFF_WIDTH-1:0]  coef_wr_data,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_ch,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    coef_drop
);
    localparam int AW = $clog2(TAPS);
    localparam int PW = WIDTH + COEFF_WIDTH;
    localparam logic [COEFF_WIDTH-1:0] COEF0_RST = {2'b01, {(COEFF_WIDTH-2){1'b0}}};

    typedef enum logic {IDLE, MAC} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0]       sbuf [2][TAPS];
    logic [AW-1:0]          wp [2];
    logic [COEFF_WIDTH-1:0] coeff [TAPS];
    logic [AW-1:0]          base, k, tap_idx;
    logic                   cur_ch, last_grant, grant, any_valid, k_last;
    logic [WIDTH-1:0]       in_data, tap_sample, sat;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] acc, acc_nxt, shifted;
    logic [ACC_WIDTH-WIDTH:0]    hi;
    logic                   pend_valid;
    logic [AW-1:0]          pend_addr;
    logic [COEFF_WIDTH-1:0] pend_data;

    // Round-robin: on a tie the channel not served last time wins.
    assign any_valid = ch0_valid | ch1_valid;
    assign grant     = (ch0_valid && ch1_valid) ? ~last_grant : ch1_valid;
    assign in_data   = grant ? ch1_data : ch0_data;
    assign k_last    = (k == {AW{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ch0_ready = 1'b0;
        ch1_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                ch0_ready = rst_n && any_valid && !grant;
                ch1_ready = rst_n && any_valid && grant;
                if (any_valid) state_nxt = MAC;
            end
            MAC: begin
                busy = 1'b1;
                if (k_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tap_idx    = base - k;
        tap_sample = sbuf[cur_ch][tap_idx];
        prod       = $signed(tap_sample) * $signed(coeff[k]);
        acc_nxt    = acc + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
        shifted    = acc_nxt >>> (COEFF_WIDTH - 1);
        hi         = shifted[ACC_WIDTH-1:WIDTH-1];
        sat        = shifted[WIDTH-1:0];
        if (hi != '0 && hi != '1)
            sat = shifted[ACC_WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                wp[c] <= '0;
                for (int i = 0; i < TAPS; i++) sbuf[c][i] <= '0;
            end
            base       <= '0;
            k          <= '0;
            cur_ch     <= 1'b0;
            last_grant <= 1'b1;
            acc        <= '0;
            out_data   <= '0;
            out_ch     <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (any_valid) begin
                    sbuf[grant][wp[grant]] <= in_data;
                    base       <= wp[grant];
                    wp[grant]  <= wp[grant] + 1'b1;
                    k          <= '0;
                    acc        <= '0;
                    cur_ch     <= grant;
                    last_grant <= grant;
                end
            end else begin
                acc <= acc_nxt;
                k   <= k + 1'b1;
                if (k_last) begin
                    out_data  <= sat;
                    out_ch    <= cur_ch;
                    out_valid <= 1'b1;
                end
            end
        end
    end

    // Writes during MAC are parked so the running result keeps its coefficients.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) coeff[i] <= (i == 0) ? COEF0_RST : '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            coef_drop  <= 1'b0;
        end else if (state == IDLE) begin
            if (coef_wr_en) coeff[coef_wr_addr] <= coef_wr_data;
        end else if (!k_last) begin
            if (coef_wr_en) begin
                pend_valid <= 1'b1;
                pend_addr  <= coef_wr_addr;
                pend_data  <= coef_wr_data;
                if (pend_valid) coef_drop <= 1'b1;
            end
        end else begin
            if (pend_valid) coeff[pend_addr] <= pend_data;
            if (coef_wr_en) begin
                coeff[coef_wr_addr] <= coef_wr_data;
                if (pend_valid && pend_addr == coef_wr_addr) coef_drop <= 1'b1;
            end
            pend_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb/tb_fir_mac_scheduler.sv - scoreboard bench for fir_mac_scheduler
module tb_fir_mac_scheduler;
    localparam int TAPS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ch0_data = '0, ch1_data = '0;
    logic        ch0_valid = 1'b0, ch1_valid = 1'b0;
    logic        ch0_ready, ch1_ready;
    logic        coef_wr_en = 1'b0;
    logic [2:0]  coef_wr_addr = '0;
    logic [15:0] coef_wr_data = '0;
    logic [31:0] out_data;
    logic        out_ch, out_valid, busy, coef_drop;

    fir_mac_scheduler #(.WIDTH(32), .COEFF_WIDTH(16), .TAPS(TAPS)) dut (
        .clk(clk), .rst_n(rst_n),
        .ch0_data(ch0_data), .ch0_valid(ch0_valid), .ch0_ready(ch0_ready),
        .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .busy(busy), .coef_drop(coef_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ch;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic glog[$];
    int   hlog[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0;
    int   busy_run = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_ch", out_ch, e.ch);
                    chk("out_latency", cyc, e.cyc);
                    chk("busy_cycles", busy_run, TAPS);
                    busy_run = 0;
                end
            end
        end
    end

    // Called and returns 1ns after a rising edge.
    task automatic send(input logic ch, input logic [31:0] d, input logic [31:0] exp, input bit want);
        int n = 0;
        if (ch) begin ch1_data = d; ch1_valid = 1'b1; end
        else    begin ch0_data = d; ch0_valid = 1'b1; end
        @(negedge clk);
        while (!(ch ? ch1_ready : ch0_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("handshake_timeout", 1, 0);
        @(posedge clk);
        #1;
        if (want) q.push_back('{ch, exp, cyc + TAPS});
        glog.push_back(ch);
        hlog.push_back(cyc);
        if (ch) ch1_valid = 1'b0;
        else    ch0_valid = 1'b0;
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
        coef_wr_en = 1'b1;
        coef_wr_addr = a;
        coef_wr_data = d;
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
    endtask

    task automatic write_all(input logic [15:0] d);
        for (int i = 0; i < TAPS; i++) write_coef(3'(i), d);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_pending", q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        ch0_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ch0_ready", ch0_ready, 0);
        chk("rst_ch1_ready", ch1_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_coef_drop", coef_drop, 0);
        ch0_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ch1_valid = 1'b1;
        #1;
        chk("idle_ch1_ready", ch1_ready, 1);
        chk("idle_ch0_ready", ch0_ready, 0);
        ch1_valid = 1'b0;
        @(posedge clk);
        #1;

        // Post-reset gain of 0.5.
        send(1'b0, 32'd1000, 32'd500, 1'b1);
        drain();

        // Impulse response with all taps at 1/8.
        do_reset();
        write_all(16'h1000);
        send(1'b0, 32'd8000, 32'd1000, 1'b1);
        for (int i = 0; i < 7; i++) send(1'b0, 32'd0, 32'd1000, 1'b1);
        send(1'b0, 32'd0, 32'd0, 1'b1);
        drain();

        // Arbitration and channel isolation.
        do_reset();
        write_all(16'h1000);
        glog.delete();
        hlog.delete();
        fork
            for (int i = 0; i < 8; i++) send(1'b0, 32'd0, 32'd0, 1'b1);
            for (int j = 0; j < 8; j++) send(1'b1, (j == 0) ? 32'd8000 : 32'd0, 32'd1000, 1'b1);
        join
        drain();
        chk("grant_count", glog.size(), 16);
        for (int i = 0; i < 16 && i < glog.size(); i++) chk("grant_order", glog[i], i % 2);
        for (int i = 1; i < 16 && i < hlog.size(); i++) chk("grant_spacing", hlog[i] - hlog[i-1], TAPS + 1);

        // Saturation, both signs.
        do_reset();
        write_all(16'h7FFF);
        send(1'b0, 32'h7FFF_FFFF, 32'h7FFE_FFFF, 1'b1);
        for (int i = 0; i < 7; i++) send(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        drain();
        do_reset();
        write_all(16'h7FFF);
        send(1'b0, 32'h8000_0000, 32'h8001_0000, 1'b1);
        for (int i = 0; i < 7; i++) send(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        drain();

        // Deferred coefficient update and overwrite detection.
        do_reset();
        send(1'b0, 32'd1000, 32'd500, 1'b1);
        @(posedge clk);
        #1;
        write_coef(3'd0, 16'h2000);
        send(1'b0, 32'd1000, 32'd250, 1'b1);
        chk("coef_drop_single", coef_drop, 0);
        write_coef(3'd1, 16'h7000);
        write_coef(3'd0, 16'h4000);
        drain();
        chk("coef_drop_double", coef_drop, 1);
        send(1'b0, 32'd1000, 32'd500, 1'b1);
        drain();

        // Reset during MAC discards the operation and the pending write.
        do_reset();
        send(1'b0, 32'd1000, 32'd0, 1'b0);
        write_coef(3'd0, 16'h1000);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", ch0_ready, 0);
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
            if (i == 1) rst_n = 1'b1;
        end
        chk("midrst_no_out", seen, 0);
        @(posedge clk);
        #1;
        send(1'b0, 32'd1000, 32'd500, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
